// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing: pixel enable, h/v counters, registered sync/blank decode.
// Optional VGA_FRAME_CNT_EN adds a free-running 16-bit frame counter output.
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        p_tick,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_tick
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISP);
  localparam logic [10:0] V_VIS    = 11'(V_DISP);
  localparam logic [10:0] HS_START = 11'(H_DISP + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_START = 11'(V_DISP + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_DISP + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_p_tick;
  logic [10:0]      r_h, r_v, w_h_nxt, w_v_nxt;
  logic             r_hsync, r_vsync, r_video_on;
  logic             w_h_wrap, w_hs_act, w_vs_act, w_von_nxt;

  always_comb begin
    w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    w_h_wrap  = (r_h == H_LAST);
    w_h_nxt   = r_h;
    w_v_nxt   = r_v;
    // Both counters step on the edge that closes a p_tick cycle
    if (r_p_tick) begin
      w_h_nxt = w_h_wrap ? 11'd0 : r_h + 11'd1;
      if (w_h_wrap)
        w_v_nxt = (r_v == V_LAST) ? 11'd0 : r_v + 11'd1;
    end
    w_hs_act  = (w_h_nxt >= HS_START) && (w_h_nxt <= HS_END);
    w_vs_act  = (w_v_nxt >= VS_START) && (w_v_nxt <= VS_END);
    w_von_nxt = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_p_tick   <= 1'b0;
      r_h        <= '0;
      r_v        <= '0;
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_video_on <= 1'b0;
    end else begin
      r_div      <= w_div_nxt;
      r_p_tick   <= (w_div_nxt == DIV_LAST);
      r_h        <= w_h_nxt;
      r_v        <= w_v_nxt;
      r_hsync    <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on <= w_von_nxt;
    end
  end

  assign p_tick     = r_p_tick;
  assign pix_x      = r_h;
  assign pix_y      = r_v;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign video_on   = r_video_on;
  assign frame_tick = r_p_tick && (r_h == 11'd0) && (r_v == V_VIS);

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge clk) begin
    if (reset)           r_frame_cnt <= '0;
    else if (frame_tick) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign frame_cnt = r_frame_cnt;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a shrunken raster; expectations derive from cycles since reset.
module tb_vga_sync_gen;
  localparam int D  = 2;
  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT * D;

  logic clk = 1'b0, reset = 1'b1;
  logic hsync, vsync, video_on, p_tick, frame_tick;
  logic [10:0] pix_x, pix_y;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_sync_gen #(
    .CLK_DIV(D), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .p_tick(p_tick), .pix_x(pix_x), .pix_y(pix_y),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] x, y;
    logic hs, vs, von, pt, ft;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0, nprint = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (nprint < 30) begin
        nprint++;
        $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
    end
  endtask

  // Expected outputs for the k-th cycle after the last reset edge (k=0 holds reset values)
  function automatic exp_t model(input int k);
    exp_t e;
    int n;
    n     = k / D;
    e.x   = 11'(n % HT);
    e.y   = 11'((n / HT) % VT);
    e.pt  = (k % D) == D - 1;
    e.von = (k != 0) && (e.x < HD) && (e.y < VD);
    e.hs  = !((k != 0) && (e.x >= HD + HF) && (e.x < HD + HF + HS));
    e.vs  = !((k != 0) && (e.y >= VD + VF) && (e.y < VD + VF + VS));
    e.ft  = e.pt && (e.x == 0) && (e.y == VD);
    return e;
  endfunction

  int k = 0;
  bit mv = 0;
  always @(posedge clk) begin
    if (reset) begin k = 0; mv = 1; end
    else if (mv) k++;
    if (mv) sb.push_back(model(k));
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("raster", {5'd0, pix_x, pix_y, hsync, vsync, video_on, p_tick, frame_tick},
          {5'd0, e});
    end
  end

  int n_von, n_hs, n_vs, n_ft;
  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_px", {21'd0, pix_x}, 32'd0);
    chk("rst_pt", {31'd0, p_tick}, 32'd0);
    chk("rst_hs", {31'd0, hsync}, 32'd1);
    reset = 1'b0;
    n_von = 0; n_hs = 0; n_vs = 0; n_ft = 0;
    // Window of exactly three frames starting at the first post-reset cycle
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (p_tick && video_on) n_von++;
      if (p_tick && !hsync)   n_hs++;
      if (p_tick && !vsync)   n_vs++;
      if (frame_tick)         n_ft++;
      if (frame_tick) chk("ft_pos", {10'd0, pix_x, pix_y}, {21'd0, 11'(VD)});
      @(negedge clk);
    end
    chk("von_cnt", n_von, 3 * HD * VD);
    chk("hs_cnt",  n_hs,  3 * VT * HS);
    chk("vs_cnt",  n_vs,  3 * HT * VS);
    chk("ft_cnt",  n_ft,  3);
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt", {16'd0, frame_cnt}, 32'd3);
`endif
    repeat (77) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_von", {31'd0, video_on}, 32'd0);
    chk("mrst_vs",  {31'd0, vsync}, 32'd1);
    chk("mrst_py",  {21'd0, pix_y}, 32'd0);
    repeat (FRAME + 150) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing for the Space-Shooter display path.
- Produces hsync, vsync, video_on and the current pixel coordinates pix_x/pix_y. The wall/ball/bullet pixel renderer consumes these to produce rgb.
- Also provides a pixel-rate enable and a once-per-frame tick. Game logic uses the tick to update object positions during vertical blank.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz clk -> 25 MHz pixel rate); legal >= 1
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- hsync  output  1  horizontal sync, active level SYNC_POL
- vsync  output  1  vertical sync, active level SYNC_POL
- video_on  output  1  high when (pix_x, pix_y) lies in the visible area
- p_tick  output  1  one-clk pixel enable, asserted once every CLK_DIV clks
- pix_x  output  11  current horizontal count, 0..H_TOTAL-1
- pix_y  output  11  current vertical count, 0..V_TOTAL-1
- frame_tick  output  1  one-clk pulse at start of vertical blank

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Derived totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
- Pixel divider (div_cnt):
  - Counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1).
  - CLK_DIV=1 gives p_tick constantly high once out of reset.
- Horizontal counter (h_cnt):
  - Advances at the clk edge ending a p_tick cycle.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter (v_cnt):
  - Advances on the same edge as h_cnt, only when h_cnt == H_TOTAL-1.
  - Wraps from V_TOTAL-1 to 0.
- Coordinate outputs: pix_x = h_cnt and pix_y = v_cnt, driven directly from registers.
- Decoded outputs (video_on, hsync, vsync) are registered from next-state counter values, so they are always consistent with the current pix_x/pix_y with zero lag:
  - video_on = (pix_x < H_DISP) && (pix_y < V_DISP).
  - hsync is active iff H_DISP+H_FP <= pix_x <= H_DISP+H_FP+H_SYNC-1 (656..751).
  - vsync is active iff V_DISP+V_FP <= pix_y <= V_DISP+V_FP+V_SYNC-1 (490..491).
- frame_tick = p_tick && pix_x == 0 && pix_y == V_DISP. It is high for exactly one clk per frame.
- Reset values, holding for every clk while reset is high:
  - div_cnt=0, pix_x=0, pix_y=0.
  - video_on=0, p_tick=0, frame_tick=0.
  - hsync = vsync = ~SYNC_POL (inactive).
- First cycle after reset release: pix_x=0, pix_y=0, video_on=1, syncs inactive. The first p_tick occurs CLK_DIV-1 clks later.
- Reset mid-frame: takes effect on the next edge regardless of div_cnt/h_cnt/v_cnt. No partial line or sync pulse is completed.
- Line and frame lengths: a line is exactly H_TOTAL*CLK_DIV clks; a frame is exactly V_TOTAL lines.
- Simultaneous wraps: h wrap and v wrap at (H_TOTAL-1, V_TOTAL-1) occur on the same edge, landing at (0,0).

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0]. Reset value 0.
  - Increments by 1 on each frame_tick and wraps 0xFFFF -> 0.
  - Used for animation and blink timing.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
1. Release reset with CLK_DIV=2 -> p_tick first high on clk 1 after release, then every 2 clks; pix_x reads 0,0,1,1,2,... per clk.
2. Run one line -> hsync low for exactly 96 p_ticks starting at pix_x=656, high again at 752; line length 1600 clks; pix_y increments exactly when pix_x wraps 799->0.
3. Run one frame -> vsync low only for pix_y 490..491; frame length 840000 clks; (799,524) wraps to (0,0) in a single edge.
4. Count p_tick cycles with video_on=1 over one frame -> exactly 307200; video_on=0 at pix_x=640 and at pix_y=480.
5. Assert reset for 1 clk at pix_x=300, pix_y=200 -> next cycle pix_x=0, pix_y=0, video_on=0, hsync=vsync=1, p_tick=0; normal timing resumes from clk 0.
6. Run 3 frames -> frame_tick once per frame, at (0,480) coincident with p_tick; with VGA_FRAME_CNT_EN, frame_cnt reads 3, and preset 0xFFFF wraps to 0.
